// File: rtl/me_block_sequencer.sv
// me_block_sequencer: walks the motion-estimation core over a run of
// macroblocks with one four-phase req/ack transaction per block index.
// Each {min_sad, min_mvec} result is written to a result buffer, and the
// run-wide best SAD (with vector and index) and a saturating SAD total
// are tracked.
//
// Handshake: me_req rises only when me_ack is low; the core raises me_ack
// with a valid result and holds it; me_req then falls and the sequencer
// waits for me_ack to fall before the next block. A stale ack from an
// aborted run is absorbed by waiting in SETUP for me_ack=0.
module me_block_sequencer #(
    parameter int NBLK_W  = 6,
    parameter int SAD_W   = 16,
    parameter int MVEC_W  = 12,
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NBLK_W-1:0]         num_blk,
    output logic                      me_req,
    input  logic                      me_ack,
    input  logic [SAD_W-1:0]          me_min_sad,
    input  logic [MVEC_W-1:0]         me_min_mvec,
    output logic [NBLK_W-1:0]         blk_idx,
    output logic                      res_we,
    output logic [NBLK_W-1:0]         res_addr,
    output logic [SAD_W+MVEC_W-1:0]   res_data,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [SAD_W-1:0]          best_sad,
    output logic [MVEC_W-1:0]         best_mvec,
    output logic [NBLK_W-1:0]         best_idx,
    output logic [ACC_W-1:0]          sad_acc
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_NEXT    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [NBLK_W-1:0]         num_q, num_d;
    logic [NBLK_W-1:0]         blk_idx_q, blk_idx_d;
    logic                      me_req_q, me_req_d;
    logic                      res_we_q, res_we_d;
    logic [NBLK_W-1:0]         res_addr_q, res_addr_d;
    logic [SAD_W+MVEC_W-1:0]   res_data_q, res_data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [SAD_W-1:0]          best_sad_q, best_sad_d;
    logic [MVEC_W-1:0]         best_mvec_q, best_mvec_d;
    logic [NBLK_W-1:0]         best_idx_q, best_idx_d;
    logic [ACC_W-1:0]          sad_acc_q, sad_acc_d;
    logic [TO_W-1:0]           wdog_q, wdog_d;

    logic                      wdog_expired;
    logic                      last_blk;
    logic [ACC_W:0]            acc_sum;

    assign wdog_expired = (wdog_q == TO_W'(TIMEOUT - 1));
    assign last_blk     = (blk_idx_q == (num_q - NBLK_W'(1)));
    // One extra bit catches the carry used for saturation.
    assign acc_sum      = {1'b0, sad_acc_q} + {{(ACC_W + 1 - SAD_W){1'b0}}, me_min_sad};

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        blk_idx_d     = blk_idx_q;
        me_req_d      = me_req_q;
        res_we_d      = 1'b0;
        res_addr_d    = res_addr_q;
        res_data_d    = res_data_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        best_sad_d    = best_sad_q;
        best_mvec_d   = best_mvec_q;
        best_idx_d    = best_idx_q;
        sad_acc_d     = sad_acc_q;

        if (abort && (state_q != S_IDLE)) begin
            // Abort beats everything, including a same-cycle ack; partial
            // best/accumulator/index values are left as they are.
            state_d  = S_IDLE;
            me_req_d = 1'b0;
            done_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_blk != '0) begin
                            num_d         = num_blk;
                            blk_idx_d     = '0;
                            sad_acc_d     = '0;
                            timeout_err_d = 1'b0;
                            best_sad_d    = '1;
                            best_mvec_d   = '0;
                            best_idx_d    = '0;
                            state_d       = S_SETUP;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (!me_ack) begin
                        me_req_d = 1'b1;
                        state_d  = S_REQ;
                    end else if (wdog_expired) begin
                        timeout_err_d = 1'b1;
                        me_req_d      = 1'b0;
                        done_d        = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (me_ack) begin
                        res_we_d   = 1'b1;
                        res_addr_d = blk_idx_q;
                        res_data_d = {me_min_sad, me_min_mvec};
                        // Strict compare: the earliest block keeps a tie.
                        if (me_min_sad < best_sad_q) begin
                            best_sad_d  = me_min_sad;
                            best_mvec_d = me_min_mvec;
                            best_idx_d  = blk_idx_q;
                        end
                        sad_acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
                        me_req_d  = 1'b0;
                        state_d   = S_RELEASE;
                    end else if (wdog_expired) begin
                        timeout_err_d = 1'b1;
                        me_req_d      = 1'b0;
                        done_d        = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
                S_RELEASE: begin
                    if (!me_ack) begin
                        if (last_blk) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else if (wdog_expired) begin
                        timeout_err_d = 1'b1;
                        done_d        = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
                S_NEXT: begin
                    blk_idx_d = blk_idx_q + NBLK_W'(1);
                    state_d   = S_SETUP;
                end
                default: begin
                    me_req_d = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);

        // Watchdog restarts on every state change and only runs while
        // waiting on an ack edge.
        if ((state_d != state_q) || (state_d == S_IDLE) || (state_d == S_NEXT)) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + TO_W'(1);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            num_q         <= '0;
            blk_idx_q     <= '0;
            me_req_q      <= 1'b0;
            res_we_q      <= 1'b0;
            res_addr_q    <= '0;
            res_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            best_sad_q    <= '1;
            best_mvec_q   <= '0;
            best_idx_q    <= '0;
            sad_acc_q     <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            blk_idx_q     <= blk_idx_d;
            me_req_q      <= me_req_d;
            res_we_q      <= res_we_d;
            res_addr_q    <= res_addr_d;
            res_data_q    <= res_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            best_sad_q    <= best_sad_d;
            best_mvec_q   <= best_mvec_d;
            best_idx_q    <= best_idx_d;
            sad_acc_q     <= sad_acc_d;
            wdog_q        <= wdog_d;
        end
    end

    assign me_req      = me_req_q;
    assign blk_idx     = blk_idx_q;
    assign res_we      = res_we_q;
    assign res_addr    = res_addr_q;
    assign res_data    = res_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign best_sad    = best_sad_q;
    assign best_mvec   = best_mvec_q;
    assign best_idx    = best_idx_q;
    assign sad_acc     = sad_acc_q;

endmodule

// File: tb/tb_me_block_sequencer.sv
// Bench for me_block_sequencer: behavioural ME core, directed runs,
// scoreboard of expected result-buffer writes and a final report.
module tb_me_block_sequencer;

    localparam int NBLK_W  = 6;
    localparam int SAD_W   = 16;
    localparam int MVEC_W  = 12;
    localparam int ACC_W   = 17;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;
    localparam int W       = NBLK_W + SAD_W + MVEC_W;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic [NBLK_W-1:0]       num_blk;
    logic                    me_req;
    logic                    me_ack;
    logic [SAD_W-1:0]        me_min_sad;
    logic [MVEC_W-1:0]       me_min_mvec;
    logic [NBLK_W-1:0]       blk_idx;
    logic                    res_we;
    logic [NBLK_W-1:0]       res_addr;
    logic [SAD_W+MVEC_W-1:0] res_data;
    logic                    busy;
    logic                    done;
    logic                    timeout_err;
    logic [SAD_W-1:0]        best_sad;
    logic [MVEC_W-1:0]       best_mvec;
    logic [NBLK_W-1:0]       best_idx;
    logic [ACC_W-1:0]        sad_acc;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int req_cyc     = 0;
    int busy_cyc    = 0;
    int we_cnt      = 0;

    logic [W-1:0] exp_q[$];

    // Core model controls
    logic [SAD_W-1:0]  sad_tab[64];
    logic [MVEC_W-1:0] mv_tab[64];
    int ack_dly   = 5;
    int rel_dly   = 2;
    bit ack_en    = 1'b1;
    int abort_blk = -1;

    me_block_sequencer #(
        .NBLK_W(NBLK_W), .SAD_W(SAD_W), .MVEC_W(MVEC_W),
        .ACC_W(ACC_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_blk(num_blk),
        .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad),
        .me_min_mvec(me_min_mvec), .blk_idx(blk_idx), .res_we(res_we),
        .res_addr(res_addr), .res_data(res_data), .busy(busy), .done(done),
        .timeout_err(timeout_err), .best_sad(best_sad), .best_mvec(best_mvec),
        .best_idx(best_idx), .sad_acc(sad_acc)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // Behavioural ME core, also owns the abort line so an abort can be
    // placed exactly in an ack cycle.
    initial begin
        int cnt;
        cnt = 0;
        me_ack = 1'b0;
        abort = 1'b0;
        me_min_sad = '0;
        me_min_mvec = '0;
        forever begin
            @(negedge clk);
            abort = 1'b0;
            if (rst) begin
                me_ack = 1'b0;
                cnt = 0;
            end else if (!me_ack) begin
                if (me_req && ack_en) begin
                    cnt++;
                    if (cnt >= ack_dly) begin
                        me_ack = 1'b1;
                        me_min_sad = sad_tab[blk_idx];
                        me_min_mvec = mv_tab[blk_idx];
                        cnt = 0;
                        if (int'(blk_idx) == abort_blk) begin
                            abort = 1'b1;
                            abort_blk = -1;
                        end
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!me_req) begin
                cnt++;
                if (cnt >= rel_dly) begin
                    me_ack = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: every result write is checked against exp_q.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (res_we) begin
                    we_cnt++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL res_write_unexpected: got addr=%0d data=0x%0h, required no write",
                                 res_addr, res_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({res_addr, res_data} !== e) begin
                            miscompares++;
                            $display("FAIL res_write: got 0x%0h required 0x%0h", {res_addr, res_data}, e);
                        end
                    end
                end
                if (done)   done_cnt++;
                if (me_req) req_cyc++;
                if (busy)   busy_cyc++;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int addr, input logic [SAD_W-1:0] s, input logic [MVEC_W-1:0] m);
        sad_tab[addr] = s;
        mv_tab[addr] = m;
        exp_q.push_back({NBLK_W'(addr), s, m});
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        num_blk = NBLK_W'(n);
        start = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int max, output int lat);
        logic seen;
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, 64'(seen), 64'd1);
    endtask

    initial begin
        int lat, d0, r0, b0, w0, bad;
        logic fell;
        rst = 1'b1;
        start = 1'b0;
        num_blk = '0;
        for (int i = 0; i < 64; i++) begin
            sad_tab[i] = '0;
            mv_tab[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_me_req", 64'(me_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res_we", 64'(res_we), 64'd0);
        chk("rst_best_sad", 64'(best_sad), 64'hFFFF);
        chk("rst_sad_acc", 64'(sad_acc), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_blk_idx", 64'(blk_idx), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Normal run of three blocks
        push_exp(0, 16'd300, 12'h011);
        push_exp(1, 16'd120, 12'h022);
        push_exp(2, 16'd120, 12'h033);
        d0 = done_cnt;
        pulse_start(3);
        wait_done("normal_done", 200, lat);
        chk("normal_busy_with_done", 64'(busy), 64'd0);
        chk("normal_best_sad", 64'(best_sad), 64'd120);
        chk("normal_best_mvec", 64'(best_mvec), 64'h022);
        chk("normal_best_idx", 64'(best_idx), 64'd1);
        chk("normal_sad_acc", 64'(sad_acc), 64'd540);
        repeat (5) @(negedge clk);
        chk("normal_single_done", 64'(done_cnt - d0), 64'd1);
        chk("normal_all_written", 64'(exp_q.size()), 64'd0);

        // Empty run
        r0 = req_cyc; b0 = busy_cyc; w0 = we_cnt;
        pulse_start(0);
        wait_done("empty_done", 10, lat);
        chk("empty_done_latency", 64'(lat), 64'd1);
        repeat (3) @(negedge clk);
        chk("empty_no_busy", 64'(busy_cyc - b0), 64'd0);
        chk("empty_no_req", 64'(req_cyc - r0), 64'd0);
        chk("empty_no_write", 64'(we_cnt - w0), 64'd0);

        // Timeout: core never acks
        ack_en = 1'b0;
        r0 = req_cyc; w0 = we_cnt;
        pulse_start(2);
        wait_done("timeout_done", 100, lat);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        chk("timeout_req_low", 64'(me_req), 64'd0);
        chk("timeout_busy_low", 64'(busy), 64'd0);
        chk("timeout_req_cycles", 64'(req_cyc - r0), 64'd16);
        chk("timeout_no_write", 64'(we_cnt - w0), 64'd0);
        ack_en = 1'b1;

        // Next start clears the sticky error
        push_exp(0, 16'd50, 12'h0AB);
        pulse_start(1);
        @(negedge clk);
        start = 1'b0;
        chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
        wait_done("after_timeout_done", 200, lat);
        chk("after_timeout_best_sad", 64'(best_sad), 64'd50);
        chk("after_timeout_sad_acc", 64'(sad_acc), 64'd50);

        // Abort in the ack cycle of block 1 of 4
        rel_dly = 8;
        push_exp(0, 16'd10, 12'h101);
        sad_tab[1] = 16'd5;  mv_tab[1] = 12'h102;
        sad_tab[2] = 16'd30; mv_tab[2] = 12'h103;
        sad_tab[3] = 16'd40; mv_tab[3] = 12'h104;
        abort_blk = 1;
        w0 = we_cnt;
        pulse_start(4);
        wait_done("abort_done", 200, lat);
        chk("abort_busy_low", 64'(busy), 64'd0);
        chk("abort_req_low", 64'(me_req), 64'd0);
        chk("abort_best_sad", 64'(best_sad), 64'd10);
        chk("abort_best_idx", 64'(best_idx), 64'd0);
        chk("abort_sad_acc", 64'(sad_acc), 64'd10);
        chk("abort_blk_idx_held", 64'(blk_idx), 64'd1);
        chk("abort_one_write", 64'(we_cnt - w0), 64'd1);

        // Restart while the stale ack is still high: req must wait
        push_exp(0, 16'd77, 12'h0CD);
        pulse_start(1);
        @(negedge clk);
        start = 1'b0;
        chk("stale_busy_in_setup", 64'(busy), 64'd1);
        chk("stale_ack_present", 64'(me_ack), 64'd1);
        bad = 0;
        fell = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (me_req && me_ack) bad++;
            if (!me_ack) begin
                fell = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("stale_ack_fell", 64'(fell), 64'd1);
        chk("stale_req_held_low", 64'(bad), 64'd0);
        wait_done("stale_run_done", 200, lat);
        chk("stale_run_best_sad", 64'(best_sad), 64'd77);
        rel_dly = 2;

        // Saturation of the 17-bit accumulator
        push_exp(0, 16'hFFFF, 12'h001);
        push_exp(1, 16'hFFFF, 12'h002);
        push_exp(2, 16'hFFFF, 12'h003);
        push_exp(3, 16'hFFFF, 12'h004);
        pulse_start(4);
        wait_done("sat_done", 300, lat);
        chk("sat_sad_acc", 64'(sad_acc), 64'h1FFFF);
        chk("sat_best_sad", 64'(best_sad), 64'hFFFF);
        chk("sat_best_mvec_untouched", 64'(best_mvec), 64'd0);
        chk("sat_best_idx", 64'(best_idx), 64'd0);

        // Reset while block 1 is in REQ
        push_exp(0, 16'd100, 12'h0E1);
        sad_tab[1] = 16'd200; mv_tab[1] = 12'h0E2;
        sad_tab[2] = 16'd300; mv_tab[2] = 12'h0E3;
        pulse_start(3);
        fell = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (me_req && (blk_idx == NBLK_W'(1))) begin
                fell = 1'b1;
                break;
            end
        end
        chk("rstmid_reached_req", 64'(fell), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_me_req", 64'(me_req), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_blk_idx", 64'(blk_idx), 64'd0);
        chk("rstmid_res_data", 64'(res_data), 64'd0);
        chk("rstmid_best_sad", 64'(best_sad), 64'hFFFF);
        chk("rstmid_sad_acc", 64'(sad_acc), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Normal run after reset release
        push_exp(0, 16'd9, 12'h0F1);
        push_exp(1, 16'd3, 12'h0F2);
        pulse_start(2);
        wait_done("post_rst_done", 200, lat);
        chk("post_rst_best_sad", 64'(best_sad), 64'd3);
        chk("post_rst_best_idx", 64'(best_idx), 64'd1);
        chk("post_rst_sad_acc", 64'(sad_acc), 64'd12);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
